// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage
// In-order front end for the register-file/ALU stage. It fetches one RV32I word
// at a time over a req/ack handshake and decodes OP / OP-IMM into register
// indices, an ALU select and a 12-bit immediate. Each instruction is held in
// ISSUE until downstream releases stall. PC advances by 4 only on that release.
// Any word that is not a supported ALU operation is still issued, but it is
// flagged illegal and never produces a register write.
// A fetch that waits IMEM_TIMEOUT cycles without an ack parks the stage in HALT.
// Only reset leaves HALT.

module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [6:0]  opcode,
  output logic [3:0]  Opsel,
  output logic [11:0] imm_in,
  output logic        reg_write,
  output logic        dec_valid,
  output logic        illegal,
  output logic [31:0] pc_out,
  output logic        fetch_err
);

  // Major opcodes handled by the ALU datapath
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  // funct7 / imm[11:5] patterns: plain form and alternate (SUB/SRA) form
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALU select encoding seen by the datapath
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  // The counter only has to reach IMEM_TIMEOUT-1
  localparam int unsigned     CNT_W    = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ISSUE = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  // Decode result for one instruction word
  typedef struct packed {
    logic       ill;
    logic [3:0] opsel;
    logic [11:0] imm;
  } dec_t;

  // ALU select from funct3 alone, using the plain (non-alternate) encodings
  function automatic logic [3:0] base_opsel(input logic [2:0] f3);
    logic [3:0] sel;
    case (f3)
      3'b000:  sel = OP_ADD;
      3'b001:  sel = OP_SLL;
      3'b010:  sel = OP_SLT;
      3'b011:  sel = OP_SLTU;
      3'b100:  sel = OP_XOR;
      3'b101:  sel = OP_SRL;
      3'b110:  sel = OP_OR;
      default: sel = OP_AND;
    endcase
    return sel;
  endfunction

  // Full decode. An illegal word always reports Opsel=0 and imm=0,
  // so downstream never sees a half-valid operation.
  function automatic dec_t decode(input logic [31:0] instr);
    dec_t       d;
    logic [6:0] f7;
    logic [2:0] f3;
    f7      = instr[31:25];
    f3      = instr[14:12];
    d.ill   = 1'b1;
    d.opsel = OP_ADD;
    d.imm   = 12'd0;
    case (instr[6:0])
      OPC_OP: begin
        if (f7 == F7_BASE) begin
          d.ill   = 1'b0;
          d.opsel = base_opsel(f3);
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          d.ill   = 1'b0;
          d.opsel = OP_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          d.ill   = 1'b0;
          d.opsel = OP_SRA;
        end
      end
      OPC_OPIMM: begin
        // The shift-immediates constrain imm[11:5]; there is no SUBI.
        case (f3)
          3'b001: begin
            if (f7 == F7_BASE) begin
              d.ill   = 1'b0;
              d.opsel = OP_SLL;
            end
          end
          3'b101: begin
            if (f7 == F7_BASE) begin
              d.ill   = 1'b0;
              d.opsel = OP_SRL;
            end else if (f7 == F7_ALT) begin
              d.ill   = 1'b0;
              d.opsel = OP_SRA;
            end
          end
          default: begin
            d.ill   = 1'b0;
            d.opsel = base_opsel(f3);
          end
        endcase
        if (!d.ill) begin
          d.imm = instr[31:20];
        end
      end
      default: ;
    endcase
    return d;
  endfunction

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fetch_err;
  logic             r_dec_valid;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic [4:0]       r_rd;
  logic [6:0]       r_opcode;
  logic [3:0]       r_opsel;
  logic [11:0]      r_imm;
  logic             r_illegal;

  dec_t             w_dec;

  assign w_dec = decode(imem_rdata);

  // Fetch/issue/halt sequencing. Decoded fields are captured on the ack edge
  // and held for the whole issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_cnt       <= '0;
      r_fetch_err <= 1'b0;
      r_dec_valid <= 1'b0;
      r_rs1       <= 5'd0;
      r_rs2       <= 5'd0;
      r_rd        <= 5'd0;
      r_opcode    <= 7'd0;
      r_opsel     <= 4'd0;
      r_imm       <= 12'd0;
      r_illegal   <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            r_rs1       <= imem_rdata[19:15];
            r_rs2       <= imem_rdata[24:20];
            r_rd        <= imem_rdata[11:7];
            r_opcode    <= imem_rdata[6:0];
            r_opsel     <= w_dec.opsel;
            r_imm       <= w_dec.imm;
            r_illegal   <= w_dec.ill;
            r_cnt       <= '0;
            r_dec_valid <= 1'b1;
            r_state     <= S_ISSUE;
          end else if (r_cnt == CNT_LAST) begin
            r_fetch_err <= 1'b1;
            r_state     <= S_HALT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ISSUE: begin
          if (!stall) begin
            r_pc        <= r_pc + 32'd4;
            r_dec_valid <= 1'b0;
            r_state     <= S_FETCH;
          end
        end
        S_HALT: ;
        default: begin
          r_dec_valid <= 1'b0;
          r_state     <= S_HALT;
        end
      endcase
    end
  end

  // Request is suppressed while reset is held, even though the state is already FETCH.
  assign imem_req  = (r_state == S_FETCH) && !reset;
  assign imem_addr = r_pc;
  assign pc_out    = r_pc;
  assign fetch_err = r_fetch_err;
  assign dec_valid = r_dec_valid;
  assign rs1       = r_rs1;
  assign rs2       = r_rs2;
  assign rd        = r_rd;
  assign opcode    = r_opcode;
  assign Opsel     = r_opsel;
  assign imm_in    = r_imm;
  assign illegal   = r_illegal;

  // A write fires only in the single issue cycle in which downstream accepts.
  assign reg_write = r_dec_valid && !stall && !r_illegal;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Bench for fetch_decode_stage: directed and random instruction streams,
// imem timeout, and PC wrap on a second instance.

module tb_fetch_decode_stage;

  logic        clk = 1'b0;
  logic        reset, imem_ack, stall;
  logic [31:0] imem_rdata;
  logic        imem_req, reg_write, dec_valid, illegal, fetch_err;
  logic [31:0] imem_addr, pc_out;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  opcode;
  logic [3:0]  Opsel;
  logic [11:0] imm_in;

  logic        reset2, imem_ack2, stall2;
  logic [31:0] imem_rdata2;
  logic        imem_req2, reg_write2, dec_valid2, illegal2, fetch_err2;
  logic [31:0] imem_addr2, pc_out2;
  logic [4:0]  rs1_2, rs2_2, rd_2;
  logic [6:0]  opcode2;
  logic [3:0]  Opsel2;
  logic [11:0] imm_in2;

  always #5 clk = ~clk;

  fetch_decode_stage #(.RESET_PC(32'h0000_0000), .IMEM_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .rs1(rs1), .rs2(rs2), .rd(rd), .opcode(opcode), .Opsel(Opsel),
    .imm_in(imm_in), .reg_write(reg_write), .dec_valid(dec_valid),
    .illegal(illegal), .pc_out(pc_out), .fetch_err(fetch_err)
  );

  fetch_decode_stage #(.RESET_PC(32'hFFFF_FFFC), .IMEM_TIMEOUT(3)) dut_wrap (
    .clk(clk), .reset(reset2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .stall(stall2),
    .rs1(rs1_2), .rs2(rs2_2), .rd(rd_2), .opcode(opcode2), .Opsel(Opsel2),
    .imm_in(imm_in2), .reg_write(reg_write2), .dec_valid(dec_valid2),
    .illegal(illegal2), .pc_out(pc_out2), .fetch_err(fetch_err2)
  );

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opc;
    logic [3:0]  opsel;
    logic [11:0] imm;
    logic        ill;
    int          delay;
    int          stl;
  } rec_t;

  rec_t        prog[$];
  rec_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_pc = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // funct3 that encodes each ALU select (inverse of the decode table)
  function automatic logic [2:0] op2f3(input int op);
    case (op)
      0, 1:    return 3'b000;
      2:       return 3'b001;
      3:       return 3'b010;
      4:       return 3'b011;
      5:       return 3'b100;
      6, 7:    return 3'b101;
      8:       return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  function automatic rec_t mk(input logic [31:0] w, input logic [4:0] a, input logic [4:0] b,
                              input logic [4:0] d, input logic [6:0] opc, input logic [3:0] sel,
                              input logic [11:0] imm, input logic ill, input int dly, input int stl);
    rec_t r;
    r.instr = w; r.rs1 = a; r.rs2 = b; r.rd = d; r.opc = opc; r.opsel = sel;
    r.imm = imm; r.ill = ill; r.delay = dly; r.stl = stl;
    return r;
  endfunction

  // Random instruction built from a chosen operation, so the expectation is known up front
  function automatic rec_t gen();
    rec_t        r;
    int          cat, op, idx;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm;
    logic [4:0]  a, b, d;
    logic [31:0] w;
    a = 5'($urandom); b = 5'($urandom); d = 5'($urandom);
    cat = $urandom_range(0, 9);
    r.delay = $urandom_range(0, 3);
    r.stl = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
    r.ill = 1'b0; r.imm = 12'd0; r.opsel = 4'd0;
    if (cat <= 3) begin
      op = $urandom_range(0, 9);
      f7 = (op == 1 || op == 7) ? 7'h20 : 7'h00;
      r.instr = {f7, b, a, op2f3(op), d, 7'h33};
      r.rs1 = a; r.rs2 = b; r.rd = d; r.opc = 7'h33; r.opsel = 4'(op);
    end else if (cat <= 6) begin
      idx = $urandom_range(0, 8);
      op  = (idx == 0) ? 0 : idx + 1;
      imm = 12'($urandom);
      if (op == 2 || op == 6) imm[11:5] = 7'h00;
      if (op == 7) imm[11:5] = 7'h20;
      r.instr = {imm, a, op2f3(op), d, 7'h13};
      r.rs1 = a; r.rs2 = imm[4:0]; r.rd = d; r.opc = 7'h13; r.opsel = 4'(op); r.imm = imm;
    end else if (cat == 7) begin
      f3 = 3'($urandom); f7 = 7'($urandom);
      if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) f7 = 7'h01;
      r.instr = {f7, b, a, f3, d, 7'h33};
      r.rs1 = a; r.rs2 = b; r.rd = d; r.opc = 7'h33; r.ill = 1'b1;
    end else if (cat == 8) begin
      f3  = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'b101;
      imm = 12'($urandom);
      if (f3 == 3'b001 && imm[11:5] == 7'h00) imm[11:5] = 7'h01;
      if (f3 == 3'b101 && (imm[11:5] == 7'h00 || imm[11:5] == 7'h20)) imm[11:5] = 7'h7F;
      r.instr = {imm, a, f3, d, 7'h13};
      r.rs1 = a; r.rs2 = imm[4:0]; r.rd = d; r.opc = 7'h13; r.ill = 1'b1;
    end else begin
      w = $urandom;
      if (w[6:0] == 7'h33 || w[6:0] == 7'h13) w[6:0] = 7'h03;
      r.instr = w;
      r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.rd = w[11:7]; r.opc = w[6:0]; r.ill = 1'b1;
    end
    return r;
  endfunction

  // Monitor: checks every fetch address and every issue cycle against the scoreboard
  always @(negedge clk) begin
    rec_t e;
    if (reset) begin
      model_pc = 32'h0;
    end else begin
      if (imem_req) begin
        chk("fetch_addr", imem_addr, model_pc);
        chk("fetch_pc_out", pc_out, model_pc);
        chk("fetch_no_write", 32'(reg_write), 32'd0);
        chk("fetch_no_valid", 32'(dec_valid), 32'd0);
        chk("fetch_err_clear", 32'(fetch_err), 32'd0);
      end
      if (dec_valid) begin
        if (sb.size() == 0) begin
          chk("issue_without_fetch", 32'd1, 32'd0);
        end else begin
          e = sb[0];
          chk("rs1", 32'(rs1), 32'(e.rs1));
          chk("rs2", 32'(rs2), 32'(e.rs2));
          chk("rd", 32'(rd), 32'(e.rd));
          chk("opcode", 32'(opcode), 32'(e.opc));
          chk("Opsel", 32'(Opsel), 32'(e.opsel));
          chk("imm_in", 32'(imm_in), 32'(e.imm));
          chk("illegal", 32'(illegal), 32'(e.ill));
          chk("issue_pc", pc_out, model_pc);
          chk("reg_write", 32'(reg_write), 32'(!stall && !e.ill));
          chk("issue_no_req", 32'(imem_req), 32'd0);
          if (!stall) begin
            void'(sb.pop_front());
            model_pc = model_pc + 32'd4;
          end
        end
      end
    end
  end

  initial begin
    rec_t cur;
    bit   have_cur, done;
    int   wt, stall_left, n;

    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
    reset2 = 1'b1; imem_ack2 = 1'b0; imem_rdata2 = 32'h0; stall2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(dec_valid), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_write", 32'(reg_write), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_fields", {7'd0, rd, Opsel, imm_in, 4'd0}, 32'd0);

    // Directed words first, then a random stream
    prog.push_back(mk(32'h0050_0093, 5'd0, 5'd5, 5'd1, 7'h13, 4'd0, 12'h005, 1'b0, 1, 0));
    prog.push_back(mk(32'h4020_81B3, 5'd1, 5'd2, 5'd3, 7'h33, 4'd1, 12'h000, 1'b0, 0, 3));
    prog.push_back(mk(32'h0000_2083, 5'd0, 5'd0, 5'd1, 7'h03, 4'd0, 12'h000, 1'b1, 0, 0));
    prog.push_back(mk(32'h4020_D193, 5'd1, 5'd2, 5'd3, 7'h13, 4'd7, 12'h402, 1'b0, 2, 1));
    prog.push_back(mk(32'h0220_D1B3, 5'd1, 5'd2, 5'd3, 7'h33, 4'd0, 12'h000, 1'b1, 0, 2));
    for (int i = 0; i < 80; i++) prog.push_back(gen());

    reset = 1'b0;
    have_cur = 1'b0; done = 1'b0; wt = 0; stall_left = 0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      if (imem_req) begin
        stall = 1'b0;
        if (!have_cur && prog.size() == 0) begin
          imem_ack = 1'b0;
          done = 1'b1;
        end else begin
          if (!have_cur) begin
            cur = prog.pop_front(); have_cur = 1'b1; wt = 0;
          end
          if (wt >= cur.delay) begin
            imem_ack = 1'b1; imem_rdata = cur.instr;
            sb.push_back(cur); stall_left = cur.stl; have_cur = 1'b0;
          end else begin
            imem_ack = 1'b0; imem_rdata = $urandom; wt++;
          end
        end
      end else begin
        imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
        if (stall_left > 0) begin stall = 1'b1; stall_left--; end
        else stall = 1'b0;
      end
      if (!done) begin
        @(posedge clk);
        #1;
      end
    end
    chk("stream_complete", 32'(done), 32'd1);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    // Timeout: now in the first FETCH cycle with no ack ever
    imem_ack = 1'b0; stall = 1'b0;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (imem_req) n++;
      else break;
    end
    chk("timeout_req_cycles", 32'(n), 32'd16);
    chk("halt_err", 32'(fetch_err), 32'd1);
    chk("halt_req", 32'(imem_req), 32'd0);
    chk("halt_valid", 32'(dec_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
      @(posedge clk);
      #1;
      chk("halt_sticky", {29'd0, fetch_err, imem_req, dec_valid}, 32'b100);
    end
    imem_ack = 1'b0;

    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_req_low", 32'(imem_req), 32'd0);
    chk("reset_err_clear", 32'(fetch_err), 32'd0);
    chk("reset_pc", pc_out, 32'h0);
    reset = 1'b0;
    #1;
    chk("after_reset_req", 32'(imem_req), 32'd1);
    chk("after_reset_addr", imem_addr, 32'h0);

    // Second instance: PC wrap and a short timeout
    @(posedge clk);
    #1;
    chk("wrap_rst_pc", pc_out2, 32'hFFFF_FFFC);
    chk("wrap_rst_req", 32'(imem_req2), 32'd0);
    reset2 = 1'b0;
    #1;
    chk("wrap_fetch_addr", imem_addr2, 32'hFFFF_FFFC);
    imem_ack2 = 1'b1; imem_rdata2 = 32'h0050_0093;
    @(posedge clk);
    #1;
    imem_ack2 = 1'b0;
    chk("wrap_issue_valid", 32'(dec_valid2), 32'd1);
    chk("wrap_issue_write", 32'(reg_write2), 32'd1);
    chk("wrap_issue_imm", 32'(imm_in2), 32'h005);
    @(posedge clk);
    #1;
    chk("wrap_next_req", 32'(imem_req2), 32'd1);
    chk("wrap_next_addr", imem_addr2, 32'h0000_0000);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (imem_req2) n++;
      else break;
    end
    chk("wrap_timeout_cycles", 32'(n), 32'd3);
    chk("wrap_halt_err", 32'(fetch_err2), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
